// File: rtl/tl45_fetch.sv
// TL45 instruction fetch stage: drives the decode input buffer and issues
// req/ack fetches to instruction memory. Handles stall hold, flush redirect and faults.
module tl45_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_pipe_stall,
    input  logic        i_pipe_flush,
    input  logic [31:0] i_new_pc,
    output logic [31:0] o_buf_pc,
    output logic [31:0] o_buf_inst,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_data,
    input  logic        i_mem_err,
    output logic        o_fetch_err
);
    typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DRAIN, S_HALT} state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_old_addr;
    logic [31:0] r_hold_inst;
    logic [31:0] r_buf_pc;
    logic [31:0] r_buf_inst;
    logic        r_err;

    logic [31:0] w_pc_next;
    logic        w_new_misal;
    logic        w_pc_misal;
    logic        w_next_misal;

    assign w_pc_next    = r_pc + PC_STEP;
    assign w_new_misal  = |i_new_pc[1:0];
    assign w_pc_misal   = |r_pc[1:0];
    assign w_next_misal = |w_pc_next[1:0];

    assign o_mem_req   = (r_state == S_FETCH) || (r_state == S_DRAIN);
    // DRAIN keeps the abandoned address on the bus while r_pc already holds the target
    assign o_mem_addr  = (r_state == S_DRAIN) ? r_old_addr : r_pc;
    assign o_buf_pc    = r_buf_pc;
    assign o_buf_inst  = r_buf_inst;
    assign o_fetch_err = r_err;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_FETCH;
            r_pc        <= RESET_PC;
            r_old_addr  <= 32'd0;
            r_hold_inst <= 32'd0;
            r_buf_pc    <= 32'd0;
            r_buf_inst  <= 32'd0;
            r_err       <= 1'b0;
        end else if (i_pipe_flush) begin
            r_buf_pc   <= 32'd0;
            r_buf_inst <= 32'd0;
            r_pc       <= i_new_pc;
            r_err      <= 1'b0;
            if (r_state == S_DRAIN || (r_state == S_FETCH && !i_mem_ack)) begin
                if (r_state == S_FETCH) r_old_addr <= r_pc;
                r_state <= S_DRAIN;
            end else if (w_new_misal) begin
                // a misaligned target never reaches the bus
                r_state <= S_HALT;
                r_err   <= 1'b1;
            end else begin
                r_state <= S_FETCH;
            end
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (i_mem_ack) begin
                        if (i_mem_err) begin
                            r_buf_pc   <= 32'd0;
                            r_buf_inst <= 32'd0;
                            r_err      <= 1'b1;
                            r_state    <= S_HALT;
                        end else if (i_pipe_stall) begin
                            r_hold_inst <= i_mem_data;
                            r_state     <= S_HOLD;
                        end else begin
                            r_buf_pc   <= r_pc;
                            r_buf_inst <= i_mem_data;
                            r_pc       <= w_pc_next;
                        end
                    end else if (!i_pipe_stall) begin
                        r_buf_pc   <= 32'd0;
                        r_buf_inst <= 32'd0;
                    end
                end
                S_HOLD: begin
                    if (!i_pipe_stall) begin
                        r_buf_pc   <= r_pc;
                        r_buf_inst <= r_hold_inst;
                        r_pc       <= w_pc_next;
                        if (w_next_misal) begin
                            r_state <= S_HALT;
                            r_err   <= 1'b1;
                        end else begin
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_DRAIN: begin
                    if (i_mem_ack) begin
                        if (w_pc_misal) begin
                            r_state <= S_HALT;
                            r_err   <= 1'b1;
                        end else begin
                            r_state <= S_FETCH;
                        end
                    end
                end
                default: begin
                    r_buf_pc   <= 32'd0;
                    r_buf_inst <= 32'd0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tl45_fetch.sv
// Randomized bench for tl45_fetch: memory model, instruction-stream reference model
// and a scoreboard monitor comparing presented instructions.
module tb_tl45_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int NCYC = 6000;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_pipe_stall = 1'b0;
    logic        i_pipe_flush = 1'b0;
    logic [31:0] i_new_pc = 32'd0;
    logic [31:0] o_buf_pc;
    logic [31:0] o_buf_inst;
    logic        o_mem_req;
    logic [31:0] o_mem_addr;
    logic        i_mem_ack = 1'b0;
    logic [31:0] i_mem_data = 32'd0;
    logic        i_mem_err = 1'b0;
    logic        o_fetch_err;

    tl45_fetch #(.RESET_PC(RESET_PC), .PC_STEP(32'd4)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_pipe_stall(i_pipe_stall),
        .i_pipe_flush(i_pipe_flush), .i_new_pc(i_new_pc),
        .o_buf_pc(o_buf_pc), .o_buf_inst(o_buf_inst),
        .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr),
        .i_mem_ack(i_mem_ack), .i_mem_data(i_mem_data), .i_mem_err(i_mem_err),
        .o_fetch_err(o_fetch_err)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad = 0;
    int presented = 0;
    bit done = 0;

    // reference model: the architectural instruction stream
    logic [63:0] q[$];
    logic [31:0] m_stream = RESET_PC;
    bit          m_stale = 0;
    bit          m_halted = 0;
    bit          m_edge_err = 0;

    function automatic logic [31:0] memval(input logic [31:0] a);
        return ((a * 32'h9E37_79B1) ^ 32'h5A5A_1234) | 32'd1;
    endfunction

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // stimulus + memory model + reference model update for the coming edge
    initial begin
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge i_clk);
            i_reset      = (cyc < 2) || ($urandom_range(0, 299) == 0);
            i_pipe_stall = ($urandom_range(0, 3) == 0);
            i_pipe_flush = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 9))
                0:       i_new_pc = 32'h0000_0100 | 32'($urandom_range(1, 3));
                1, 2:    i_new_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
                default: i_new_pc = 32'($urandom_range(0, 1023) * 4);
            endcase
            i_mem_ack  = !i_reset && o_mem_req && ($urandom_range(0, 2) != 0);
            i_mem_data = i_mem_ack ? memval(o_mem_addr) : $urandom;
            i_mem_err  = i_mem_ack && ($urandom_range(0, 39) == 0);
            m_edge_err = 0;
            if (i_reset) begin
                q.delete();
                m_stream = RESET_PC;
                m_stale  = 0;
                m_halted = 0;
            end else begin
                if (o_mem_req && !m_stale)
                    chk(o_mem_addr == m_stream, "mem_addr", {32'd0, o_mem_addr}, {32'd0, m_stream});
                if (i_pipe_flush) begin
                    q.delete();
                    m_stale  = m_stale || (o_mem_req && !i_mem_ack);
                    m_stream = i_new_pc;
                    m_halted = !m_stale && (i_new_pc[1:0] != 2'd0);
                end else if (i_mem_ack) begin
                    if (m_stale) begin
                        m_stale  = 0;
                        m_halted = (m_stream[1:0] != 2'd0);
                    end else if (i_mem_err) begin
                        m_halted   = 1;
                        m_edge_err = 1;
                    end else begin
                        q.push_back({m_stream, memval(m_stream)});
                        m_stream = m_stream + 32'd4;
                    end
                end
            end
        end
        @(negedge i_clk);
        i_reset = 0; i_pipe_flush = 0; i_mem_ack = 0;
        done = 1;
        @(posedge i_clk);
        #2;
        chk(presented > 200, "presented_count", 64'(presented), 64'd200);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // monitor: compares DUT outputs just after each edge
    initial begin
        logic [63:0] prev = 64'd0;
        logic [63:0] cur;
        logic [63:0] exp;
        while (!done) begin
            @(posedge i_clk);
            #1;
            if (done) break;
            cur = {o_buf_pc, o_buf_inst};
            chk(o_fetch_err == m_halted, "fetch_err", 64'(o_fetch_err), 64'(m_halted));
            if (m_halted)
                chk(!o_mem_req, "halt_req", 64'(o_mem_req), 64'd0);
            if (i_reset) begin
                chk(cur == 64'd0, "reset_buf", cur, 64'd0);
                chk(o_mem_req && o_mem_addr == RESET_PC, "reset_req",
                    {31'd0, o_mem_req, o_mem_addr}, {32'd1, RESET_PC});
            end else if (i_pipe_flush || m_edge_err) begin
                chk(cur == 64'd0, "bubble", cur, 64'd0);
            end else if (i_pipe_stall) begin
                chk(cur == prev, "stall_hold", cur, prev);
            end else if (o_buf_inst != 32'd0) begin
                presented++;
                if (q.size() == 0) begin
                    chk(0, "unexpected_inst", cur, 64'd0);
                end else begin
                    exp = q.pop_front();
                    chk(cur == exp, "inst", cur, exp);
                end
            end else begin
                chk(o_buf_pc == 32'd0, "bubble_pc", {32'd0, o_buf_pc}, 64'd0);
            end
            prev = cur;
        end
    end
endmodule
